// File: rtl/execute_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : execute_div_unit
// Purpose  : Multi-cycle RV32M divider for the Execute stage. Handles
//            DIV/DIVU/REM/REMU with radix-2 restoring division, one quotient
//            bit per cycle. Holds the pipeline via o_Stall while busy and
//            presents the result for a single cycle (o_Done) so the
//            Execute/Memory register can capture it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : i_Clk      clock
//            i_Reset    asynchronous, active-low reset
//            i_Start    Execute holds a valid divide/remainder instruction
//            i_Op       bit0 = unsigned, bit1 = remainder (funct3[1:0])
//            i_SrcA     dividend (post-forwarding)
//            i_SrcB     divisor  (post-forwarding)
//            i_FlushE   Execute flush; aborts any operation in flight
//            o_Stall    stall request to the hazard unit (combinational)
//            o_Done     one-cycle pulse, o_Result valid
//            o_Result   quotient or remainder (held until next completion)
// Options  : DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor| finishes
//            in one cycle instead of iterating. Results are identical.
// ============================================================================
module execute_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Start,
  input  logic [1:0]      i_Op,
  input  logic [XLEN-1:0] i_SrcA,
  input  logic [XLEN-1:0] i_SrcB,
  input  logic            i_FlushE,
  output logic            o_Stall,
  output logic            o_Done,
  output logic [XLEN-1:0] o_Result
);

  localparam int                  c_CNT_W    = $clog2(XLEN);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]     c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]     c_ALL_ONES = {XLEN{1'b1}};

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_CALC = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quo;       // dividend bits shift out as quotient bits shift in
  logic [XLEN-1:0]    r_divisor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_rem;
  logic [XLEN-1:0]    r_result;

  // --------------------------------------------------------------------------
  // Operand preparation (evaluated on the accept cycle)
  // --------------------------------------------------------------------------
  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_early;
  logic            w_bypass;
  logic [XLEN-1:0] w_bypass_result;
  logic            w_idle_or_done;
  logic            w_accept;

  assign w_signed   = ~i_Op[0];
  assign w_neg_a    = w_signed & i_SrcA[XLEN-1];
  assign w_neg_b    = w_signed & i_SrcB[XLEN-1];
  assign w_abs_a    = w_neg_a ? (~i_SrcA + 1'b1) : i_SrcA;
  assign w_abs_b    = w_neg_b ? (~i_SrcB + 1'b1) : i_SrcB;
  assign w_div_zero = (i_SrcB == '0);
  assign w_overflow = w_signed & (i_SrcA == c_MIN_NEG) & (i_SrcB == c_ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_div_zero & (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_bypass = w_div_zero | w_overflow | w_early;

  // Quotient: all ones for /0, MIN for overflow, 0 for early-out.
  // Remainder: the original dividend for /0 and early-out, 0 for overflow.
  always_comb begin
    w_bypass_result = '0;
    if (i_Op[1]) begin
      w_bypass_result = w_overflow ? '0 : i_SrcA;
    end else if (w_div_zero) begin
      w_bypass_result = c_ALL_ONES;
    end else if (w_overflow) begin
      w_bypass_result = c_MIN_NEG;
    end
  end

  assign w_idle_or_done = (r_state == c_ST_IDLE) | (r_state == c_ST_DONE);
  // Gated by reset so the stall request drops immediately when reset asserts.
  assign w_accept       = i_Reset & w_idle_or_done & i_Start & ~i_FlushE;

  // --------------------------------------------------------------------------
  // One restoring step: shift {R,Q} left, subtract divisor if it fits.
  // The extra MSB of the difference is the borrow (R < divisor).
  // --------------------------------------------------------------------------
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_final;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_fits     = ~w_diff[XLEN];
  assign w_rem_next = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_fits};

  always_comb begin
    w_final = '0;
    if (r_is_rem) begin
      w_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    end else begin
      w_final = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic (flush has priority over start)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_bypass ? c_ST_DONE : c_ST_CALC;
        end else begin
          w_state_next = c_ST_IDLE;
        end
      end
      c_ST_CALC: begin
        if (i_FlushE) begin
          w_state_next = c_ST_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_next = c_ST_DONE;
        end
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_Stall = w_accept | ((r_state == c_ST_CALC) & ~i_FlushE);
    o_Done  = (r_state == c_ST_DONE);
  end

  assign o_Result = r_result;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_abs_a;
      r_divisor <= w_abs_b;
      r_neg_q   <= w_signed & (i_SrcA[XLEN-1] ^ i_SrcB[XLEN-1]);
      r_neg_r   <= w_neg_a;
      r_is_rem  <= i_Op[1];
      if (w_bypass) begin
        r_result <= w_bypass_result;
      end
    end else if ((r_state == c_ST_CALC) && !i_FlushE) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (r_cnt == c_CNT_LAST) begin
        r_result <= w_final;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_div_unit
// Purpose  : Self-checking bench for execute_div_unit. A cycle-level model
//            built from plain arithmetic predicts o_Stall/o_Done/o_Result on
//            every cycle; directed operations pin known results and latency.
//            Honours DIV_EARLY_OUT_EN for expected latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_div_unit;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Start = 1'b0;
  logic [1:0]  i_Op = 2'b00;
  logic [31:0] i_SrcA = '0;
  logic [31:0] i_SrcB = '0;
  logic        i_FlushE = 1'b0;
  logic        o_Stall;
  logic        o_Done;
  logic [31:0] o_Result;

  int n_tests = 0;
  int n_fail  = 0;

  execute_div_unit #(.XLEN(32)) dut (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Start  (i_Start),
    .i_Op     (i_Op),
    .i_SrcA   (i_SrcA),
    .i_SrcB   (i_SrcB),
    .i_FlushE (i_FlushE),
    .o_Stall  (o_Stall),
    .o_Done   (o_Done),
    .o_Result (o_Result)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit sg  = !op[0];
    bit rem = op[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sg) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] mag(input bit sg, input logic [31:0] x);
    return (sg && x[31]) ? 32'(-x) : x;
  endfunction

  // True when the operation completes one cycle after acceptance.
  function automatic bit ref_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sg = !op[0];
    if (b == 0) return 1'b1;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(sg, a) < mag(sg, b)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // --------------------------------------------------------------------------
  // Cycle model: m_left = cycles still to iterate (0 when idle/done).
  // --------------------------------------------------------------------------
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  always @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
    end else if (i_FlushE) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else if (i_Start) begin
      if (ref_fast(i_Op, i_SrcA, i_SrcB)) begin
        m_done <= 1'b1;
        m_res  <= ref_result(i_Op, i_SrcA, i_SrcB);
      end else begin
        m_done <= 1'b0;
        m_left <= 32;
        m_pend <= ref_result(i_Op, i_SrcA, i_SrcB);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge i_Clk) begin
    logic exp_stall;
    if (!i_Reset) begin
      check("rst_stall", 32'(o_Stall), 32'd0);
      check("rst_done", 32'(o_Done), 32'd0);
      check("rst_result", o_Result, 32'd0);
    end else begin
      exp_stall = ((m_left == 0) && i_Start && !i_FlushE) || ((m_left > 0) && !i_FlushE);
      check("stall", 32'(o_Stall), 32'(exp_stall));
      check("done", 32'(o_Done), 32'(m_done));
      check("result", o_Result, m_res);
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!o_Done && cyc < 40) begin
      @(posedge i_Clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    @(posedge i_Clk); #1;
    i_Start = 1'b1; i_Op = op; i_SrcA = a; i_SrcB = b;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    wait_done(cyc);
    check({nm, "_lat"}, 32'(cyc), 32'(exp_lat));
    check(nm, o_Result, exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      4: return 32'(-($urandom % 16));
      default: return $urandom;
    endcase
  endfunction

  localparam int c_EARLY_LAT =
`ifdef DIV_EARLY_OUT_EN
    1;
`else
    33;
`endif

  initial begin
    int cyc;

    // Reset state
    #12;
    check("reset_result", o_Result, 32'h0);
    check("reset_done", 32'(o_Done), 32'd0);
    check("reset_stall", 32'(o_Stall), 32'd0);
    @(posedge i_Clk); #1;
    i_Reset = 1'b1;

    // Directed results
    run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,          33);
    run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,           33);
    run_op("div_m100_7",   2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,   33);
    run_op("rem_m100_7",   2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,   33);
    run_op("rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,           33);
    run_op("div_5_0",      2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,   1);
    run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,           1);
    run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1);
    run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,           1);
    run_op("divu_3_10",    2'b01, 32'd3,          32'd10,         32'd0,           c_EARLY_LAT);
    run_op("remu_3_10",    2'b11, 32'd3,          32'd10,         32'd3,           c_EARLY_LAT);
    run_op("rem_m3_10",    2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,   c_EARLY_LAT);

    // Flush mid-CALC
    @(posedge i_Clk); #1;
    i_Start = 1'b1; i_Op = 2'b01; i_SrcA = 32'd1000; i_SrcB = 32'd3;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    repeat (9) begin @(posedge i_Clk); #1; end
    i_FlushE = 1'b1;
    #1;
    check("flush_stall", 32'(o_Stall), 32'd0);
    @(posedge i_Clk); #1;
    i_FlushE = 1'b0;
    repeat (3) begin
      check("post_flush_done", 32'(o_Done), 32'd0);
      check("post_flush_stall", 32'(o_Stall), 32'd0);
      @(posedge i_Clk); #1;
    end
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back: new start in the DONE cycle
    @(posedge i_Clk); #1;
    i_Start = 1'b1; i_Op = 2'b01; i_SrcA = 32'd20; i_SrcB = 32'd4;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    wait_done(cyc);
    check("b2b_first_lat", 32'(cyc), 32'd33);
    check("b2b_first", o_Result, 32'd5);
    i_Start = 1'b1; i_SrcA = 32'd7; i_SrcB = 32'd2;
    #1;
    check("b2b_stall", 32'(o_Stall), 32'd1);
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    wait_done(cyc);
    check("b2b_second_lat", 32'(cyc), 32'd33);
    check("b2b_second", o_Result, 32'd3);

    // Asynchronous reset mid-CALC
    @(posedge i_Clk); #1;
    i_Start = 1'b1; i_Op = 2'b01; i_SrcA = 32'd1000; i_SrcB = 32'd3;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    repeat (5) begin @(posedge i_Clk); #1; end
    #2;
    i_Reset = 1'b0;
    #1;
    check("areset_stall", 32'(o_Stall), 32'd0);
    check("areset_done", 32'(o_Done), 32'd0);
    check("areset_result", o_Result, 32'd0);
    @(posedge i_Clk); #1;
    i_Reset = 1'b1;

    // Randomized traffic: inputs change every cycle, including during CALC
    for (int i = 0; i < 3000; i++) begin
      @(posedge i_Clk); #1;
      i_Start  = (($urandom % 100) < 25);
      i_FlushE = (($urandom % 100) < 1);
      i_Op     = 2'($urandom);
      i_SrcA   = rand_operand();
      i_SrcB   = rand_operand();
    end
    @(posedge i_Clk); #1;
    i_Start = 1'b0; i_FlushE = 1'b0;
    repeat (40) @(posedge i_Clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_div_unit.md
Name: execute_div_unit

Overview:
- Multi-cycle RV32M divider in the Execute stage. It consumes the Execute-register operands (forwarded SrcA/SrcB) for DIV/DIVU/REM/REMU.
- Radix-2 restoring division, one quotient bit per cycle.
- Raises a stall request to the hazard unit while busy. Presents the result for one cycle so the Execute/Memory register can capture it.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  asynchronous, active-low reset
- i_Start  in  1  Execute holds a valid divide/remainder instruction
- i_Op  in  2  bit0=unsigned, bit1=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU; equals funct3[1:0])
- i_SrcA  in  32  dividend (post-forwarding)
- i_SrcB  in  32  divisor (post-forwarding)
- i_FlushE  in  1  hazard-unit flush of Execute; aborts operation
- o_Stall  out  1  stall request to hazard unit (holds Fetch/Decode/Execute)
- o_Done  out  1  one-cycle pulse, o_Result valid
- o_Result  out  32  quotient or remainder

Behaviour:
- Reset: async on i_Reset low. State IDLE, o_Done=0, o_Result=0, counter=0, internal registers 0.
- States:
  - IDLE: no operation in progress.
  - CALC: iterating.
  - DONE: result presented; lasts exactly one cycle.
- Start acceptance: i_Start sampled high in IDLE or DONE with i_FlushE low. Back-to-back operations are allowed.
- On accept, capture:
  - |SrcA| and |SrcB|; magnitudes are used only for signed ops.
  - neg_q = signed & (SrcA[31]^SrcB[31]).
  - neg_r = signed & SrcA[31].
  - Op latch.
  - Clear remainder register and counter.
- Special cases bypass CALC; state goes directly to DONE on the next edge:
  - Divisor 0: quotient 0xFFFFFFFF (DIV and DIVU); remainder = SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- CALC iteration, 32 cycles, counter 0..31:
  - {R,Q} shifted left 1.
  - If R >= divisor then R -= divisor and Q[0]=1.
- At counter==31 the state moves to DONE. The registered o_Result is written on the same edge:
  - quotient, or remainder per Op bit1;
  - quotient negated if neg_q; remainder negated if neg_r.
- Latency:
  - Normal ops: o_Done high exactly 33 cycles after the cycle i_Start is accepted.
  - Special cases: 1 cycle.
- o_Stall, combinational:
  - high when (IDLE|DONE) & i_Start & ~i_FlushE, or when state==CALC;
  - low in DONE unless a new start is accepted.
  - The pipeline therefore advances on the DONE cycle, and the Execute/Memory register captures o_Result.
- o_Done: high only in DONE. o_Result holds its value until the next DONE write; it is not cleared in IDLE.
- i_FlushE in CALC or DONE: next state IDLE, no o_Done pulse, o_Result unchanged, o_Stall low that cycle.
- Flush has priority over start.
- i_Start while in CALC is ignored; operands are already latched. Input changes during CALC have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: on accept, if |SrcA| < |SrcB| (unsigned compare of magnitudes, divisor nonzero), go directly to DONE with quotient 0 and remainder = SrcA (signed value restored). Latency 1 cycle.
- Undefined: such cases run the full 32 iterations with identical results and 33-cycle latency.
- Results are bit-identical either way.

Test Plan:
- DIVU 100/7 -> 33 cycles stall; o_Done with o_Result=14. REMU same operands -> o_Result=2.
- DIV 0xFFFFFF9C(-100)/7 -> o_Result=0xFFFFFFF2(-14). REM -100/7 -> 0xFFFFFFFE(-2). REM 100/-7 -> 2.
- DIV 5/0 -> o_Done next cycle with 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0.
- Start DIVU 1000/3, assert i_FlushE at cycle 10 -> IDLE next cycle, no o_Done, o_Stall low. Immediate new start 9/3 -> o_Result=3 after 33 cycles.
- Back-to-back: new i_Start in the DONE cycle of 20/4 -> first o_Result=5. Second op accepted without an IDLE cycle.
- Early-out 3/10: with DIV_EARLY_OUT_EN, o_Done after 1 cycle. Without it, after 33. o_Result=0 (DIVU) or 3 (REMU) in both builds.
- Async reset asserted mid-CALC -> o_Stall, o_Done, o_Result all 0 immediately.
